handshake_dst_buffer: RTL and testbench

- Destination-domain receiver for the handshake CDC synchronizer.
- Captures each one-cycle valid pulse and its data word from the synchronizer into a small FIFO.
- Drives the synchronizer's busy input as backpressure.
- Presents words to the downstream NTT coefficient loader on a valid/ready stream, and counts words per frame for frame-complete signalling.

---
 rtl/handshake_dst_buffer.sv | 72 +++++++
 tb/tb_handshake_dst_buffer.sv | 123 ++++++++++++
 2 files changed

// File: rtl/handshake_dst_buffer.sv
// handshake_dst_buffer: CDC destination FIFO with busy backpressure, valid/ready output and frame counting
module handshake_dst_buffer #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 4,
    parameter int FRAME_LEN = 128
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_busy,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic                       frame_done,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       ovf_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int FW = $clog2(FRAME_LEN);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0]    level_q, level_d;
    logic [FW-1:0]    fcnt_q, fcnt_d;
    logic             fdone_q, fdone_d, ovf_q, ovf_d;
    logic             push, pop, last;

    always_comb begin
        pop     = (level_q != '0) && out_ready;
        push    = in_valid && (level_q < LW'(DEPTH) || pop);
        last    = pop && (fcnt_q == FW'(FRAME_LEN - 1));
        mem_d   = mem_q;
        if (push) mem_d[wr_q] = in_data;
        wr_d    = push ? wr_q + 1'b1 : wr_q;
        rd_d    = pop ? rd_q + 1'b1 : rd_q;
        level_d = level_q + LW'(push) - LW'(pop);
        fcnt_d  = last ? '0 : (pop ? fcnt_q + 1'b1 : fcnt_q);
        fdone_d = last;
        // a pulse that finds no free slot is lost; flag it until reset
        ovf_d   = ovf_q | (in_valid & ~push);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            fcnt_q  <= '0;
            fdone_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            fcnt_q  <= fcnt_d;
            fdone_q <= fdone_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_busy    = (level_q == LW'(DEPTH));
    assign out_valid  = (level_q != '0);
    assign out_data   = mem_q[rd_q];
    assign frame_done = fdone_q;
    assign level      = level_q;
    assign ovf_err    = ovf_q;
endmodule

// File: tb/tb_handshake_dst_buffer.sv
// tb_handshake_dst_buffer: directed scoreboard bench for handshake_dst_buffer (DEPTH=4, FRAME_LEN=128)
module tb_handshake_dst_buffer;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        in_valid = 0;
    logic [31:0] in_data = 0;
    logic        in_busy, out_valid, out_ready = 0, frame_done, ovf_err;
    logic [31:0] out_data;
    logic [2:0]  level;

    int          total = 0, bad = 0;
    logic [31:0] sb[$];
    int          mf = 0, fd_cnt = 0;
    logic        m_ovf = 0, exp_fd = 0;

    handshake_dst_buffer #(.WIDTH(32), .DEPTH(4), .FRAME_LEN(128)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_busy(in_busy),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .frame_done(frame_done), .level(level), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic post_chk();
        chk("level", 32'(level), 32'(sb.size()));
        chk("in_busy", 32'(in_busy), 32'(sb.size() == 4));
        chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
        chk("frame_done", 32'(frame_done), 32'(exp_fd));
        if (frame_done) fd_cnt++;
    endtask

    // Called at a negedge: scoreboard pops/compares the head, then one clock is taken.
    task automatic cyc(input logic v, input logic [31:0] d, input logic r);
        logic p, w;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        p = (sb.size() != 0) && r;
        w = v && (sb.size() < 4 || p);
        exp_fd = 0;
        if (p) begin
            chk("pop_data", out_data, sb.pop_front());
            if (mf == 127) begin mf = 0; exp_fd = 1; end else mf++;
        end
        if (w) sb.push_back(d);
        if (v && !w) m_ovf = 1;
        @(negedge clk);
        in_valid  = 0;
        out_ready = 0;
        post_chk();
    endtask

    task automatic do_reset();
        rst_n = 0;
        sb.delete();
        mf = 0;
        m_ovf = 0;
        exp_fd = 0;
        #1;
        post_chk();
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        post_chk();
        rst_n = 1;
        cyc(0, 0, 1);
        // single word
        cyc(1, 32'hDEADBEEF, 0);
        chk("head_single", out_data, 32'hDEADBEEF);
        cyc(0, 0, 1);
        // fill to full, then one pop releases busy
        for (int i = 1; i <= 4; i++) cyc(1, 32'(i), 0);
        cyc(0, 0, 1);
        chk("head_after_pop", out_data, 32'd2);
        repeat (3) cyc(0, 0, 1);
        // simultaneous push+pop at full
        for (int i = 1; i <= 4; i++) cyc(1, 32'(i), 0);
        cyc(1, 32'd5, 1);
        repeat (4) cyc(0, 0, 1);
        // overflow drops the word and sets the sticky flag
        for (int i = 16; i <= 19; i++) cyc(1, 32'(i), 0);
        cyc(1, 32'h0BAD, 0);
        cyc(0, 0, 0);
        repeat (4) cyc(0, 0, 1);
        cyc(0, 0, 1);
        // frame counting and pointer wrap on a clean start
        do_reset();
        fd_cnt = 0;
        for (int i = 0; i < 130; i++) cyc(1, 32'(i), 1);
        cyc(0, 0, 1);
        chk("fd_count", 32'(fd_cnt), 32'd1);
        // reset mid-stream restarts the frame count
        for (int i = 0; i < 20; i++) cyc(1, 32'(1000 + i), 1);
        do_reset();
        fd_cnt = 0;
        for (int i = 0; i < 127; i++) cyc(1, 32'(i), 1);
        cyc(0, 0, 1);
        chk("fd_none_127", 32'(fd_cnt), 32'd0);
        cyc(1, 32'd500, 1);
        cyc(0, 0, 1);
        chk("fd_after_restart", 32'(fd_cnt), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
